uart_receiver: RTL and testbench

- UART receive-side partner to the board's UART transmit block. Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) from the asynchronous RxD line.
- Presents each received byte on a valid/ready holding register to downstream logic (command decoder / display path).
- Flags framing errors and overruns.
- Runs on the single system clock. Bit timing comes from a clocks-per-bit counter, with one sample taken at mid-bit.

---
 rtl/uart_receiver_if.sv | 39 +++
 rtl/uart_receiver.sv | 152 +++++++++++++++
 tb/tb_uart_receiver.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if
//   Byte-delivery channel between the UART receiver and its downstream consumer.
//   The receiver presents a byte on rx_data/rx_valid. The consumer takes it by raising
//   rx_ready while rx_valid is high at a rising edge.
//   frame_err and overrun are one-cycle status pulses that travel on the same channel.
//
//   Signals:
//     rx_data   [7:0]  receiver -> consumer   received byte, held stable while rx_valid is high
//     rx_valid         receiver -> consumer   a held byte is available
//     rx_ready         consumer -> receiver   the consumer accepts the held byte
//     frame_err        receiver -> consumer   the stop bit was low, so the byte was discarded
//     overrun          receiver -> consumer   a byte was dropped because the holding register was full
//
//   Modports:
//     master  receiver side
//     slave   consumer side
interface uart_receiver_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver
//   8N1 UART receiver: 1 start bit, 8 data bits LSB-first, 1 stop bit.
//   RxD is brought into the clk domain through a 2-flop synchronizer.
//   Each bit is sampled once, at mid-bit. The timing comes from a clocks-per-bit counter.
//   Each good byte goes into a valid/ready holding register.
//   A low stop bit gives a frame_err pulse. The receiver then waits in BREAK until the line returns high.
//   A byte that completes while the holding register is still full is dropped, and overrun pulses.
//
//   Ports:
//     clk     in   system clock, rising edge
//     reset   in   asynchronous reset, active low
//     RxD     in   UART line, asynchronous to clk, idle high
//     busy    out  high in every state except IDLE
//     rx_if   master side of uart_receiver_if (rx_data, rx_valid, rx_ready, frame_err, overrun)
module uart_receiver #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            RxD,
    output logic            busy,
    uart_receiver_if.master rx_if
);

    localparam logic [13:0] BIT_LAST  = 14'(CLKS_PER_BIT - 1);
    localparam logic [13:0] HALF_LAST = 14'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t      state_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic [13:0] clk_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        frame_err_q;
    logic        overrun_q;
    logic        busy_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // The synchronizer resets to the idle-line level, so reset does not look like a start edge.
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_meta_q   <= RxD;
            rx_s_q      <= rx_meta_q;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            clk_cnt_q   <= clk_cnt_q + 14'd1;

            // A plain handshake consumes the held byte.
            // A delivery in the same cycle overrides this clear further down.
            if (rx_valid_q && rx_if.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    clk_cnt_q <= '0;
                    if (!rx_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        if (!rx_s_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            // The line was high again at mid-start, so treat the low pulse as a glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end

                S_DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            if (!rx_valid_q || rx_if.rx_ready) begin
                                rx_data_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    // Keep the counter parked, because BREAK can last any length of time.
                    clk_cnt_q <= '0;
                    if (rx_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_if.rx_data   = rx_data_q;
    assign rx_if.rx_valid  = rx_valid_q;
    assign rx_if.frame_err = frame_err_q;
    assign rx_if.overrun   = overrun_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;
    localparam int LAT  = 2 + HALF + 9 * CPB + 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic RxD   = 1'b1;
    logic busy;

    uart_receiver_if rx_if ();

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .RxD   (RxD),
        .busy  (busy),
        .rx_if (rx_if)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed events, gathered by the monitor below.
    int         valid_rises = 0;
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         both_cnt = 0;
    int         busy_cnt = 0;
    int         rise_cyc = 0;
    int         start_cyc = 0;
    logic       prev_valid = 1'b0;
    bit         auto_ack = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Monitor and automatic consumer, sampled on the falling edge.
    // In auto mode the consumer raises rx_ready for one cycle for each held byte and records that byte.
    initial begin
        rx_if.rx_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_if.rx_valid && !prev_valid) begin
                valid_rises++;
                rise_cyc = cyc;
                $display("cycle %0d: rx byte 0x%02h", cyc, rx_if.rx_data);
            end
            prev_valid = rx_if.rx_valid;
            if (rx_if.frame_err) fe_cnt++;
            if (rx_if.overrun) ov_cnt++;
            if (rx_if.frame_err && rx_if.overrun) both_cnt++;
            if (busy) busy_cnt++;
            if (auto_ack) begin
                if (rx_if.rx_valid && !rx_if.rx_ready) begin
                    got_q.push_back(rx_if.rx_data);
                    rx_if.rx_ready = 1'b1;
                end else begin
                    rx_if.rx_ready = 1'b0;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        @(posedge clk);
        valid_rises = 0;
        fe_cnt      = 0;
        ov_cnt      = 0;
        busy_cnt    = 0;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic idle_bits(input int n);
        RxD = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Sends one 8N1 frame, LSB first, with the given stop-bit level. Call it on a falling edge.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        RxD = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            repeat (CPB) @(negedge clk);
        end
        RxD = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic manual_ack();
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int n;
        logic [7:0] b;

        // Reset values
        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_data", rx_if.rx_data, 8'h00);
        check_eq("rst_valid", rx_if.rx_valid, 1'b0);
        check_eq("rst_ferr", rx_if.frame_err, 1'b0);
        check_eq("rst_ovr", rx_if.overrun, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        reset = 1'b1;
        idle_bits(2);

        // Clean byte, with no consumer
        clear_counts();
        send_frame(8'hA5, 1'b1);
        idle_bits(2);
        lat = rise_cyc - start_cyc;
        check_eq("a5_rises", valid_rises, 1);
        check_eq("a5_valid", rx_if.rx_valid, 1'b1);
        check_eq("a5_data", rx_if.rx_data, 8'hA5);
        check_eq("a5_ferr", fe_cnt, 0);
        check_eq("a5_ovr", ov_cnt, 0);
        check_eq("a5_latency_in_range", (lat >= LAT - 1 && lat <= LAT + 1), 1'b1);
        check_eq("a5_busy_span", (busy_cnt >= LAT - 4 && busy_cnt <= LAT - 2), 1'b1);
        manual_ack();
        check_eq("a5_ack_clears", rx_if.rx_valid, 1'b0);

        // Back-to-back frames, with the consumer accepting each byte
        clear_counts();
        auto_ack = 1'b1;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(2);
        check_eq("b2b_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check_eq("b2b_first", got_q[0], 8'h00);
            check_eq("b2b_second", got_q[1], 8'hFF);
        end
        check_eq("b2b_ovr", ov_cnt, 0);
        auto_ack = 1'b0;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;

        // Overrun: the second byte arrives while the first is still held
        clear_counts();
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle_bits(2);
        check_eq("ovr_data", rx_if.rx_data, 8'h3C);
        check_eq("ovr_valid", rx_if.rx_valid, 1'b1);
        check_eq("ovr_pulses", ov_cnt, 1);
        check_eq("ovr_rises", valid_rises, 1);
        manual_ack();

        // Framing error, then the line held low (break)
        clear_counts();
        send_frame(8'h55, 1'b0);
        repeat (40 * CPB) @(negedge clk);
        check_eq("brk_ferr", fe_cnt, 1);
        check_eq("brk_rises", valid_rises, 0);
        check_eq("brk_busy_held", busy, 1'b1);
        idle_bits(2);
        check_eq("brk_busy_released", busy, 1'b0);
        send_frame(8'h81, 1'b1);
        idle_bits(2);
        check_eq("brk_next_data", rx_if.rx_data, 8'h81);
        check_eq("brk_next_valid", rx_if.rx_valid, 1'b1);
        manual_ack();

        // Glitch on the start bit
        clear_counts();
        RxD = 1'b0;
        repeat (3) @(negedge clk);
        RxD = 1'b1;
        idle_bits(2);
        check_eq("glitch_valid", valid_rises, 0);
        check_eq("glitch_ferr", fe_cnt, 0);
        check_eq("glitch_busy_seen", (busy_cnt > 0), 1'b1);
        check_eq("glitch_idle", busy, 1'b0);

        // Asynchronous reset in the middle of a frame
        clear_counts();
        fork
            send_frame(8'h96, 1'b1);
            begin
                repeat (5 * CPB + CPB / 2) @(negedge clk);
                check_eq("arst_busy_before", busy, 1'b1);
                #1 reset = 1'b0;
                #1;
                check_eq("arst_data", rx_if.rx_data, 8'h00);
                check_eq("arst_valid", rx_if.rx_valid, 1'b0);
                check_eq("arst_busy", busy, 1'b0);
                check_eq("arst_ferr", rx_if.frame_err, 1'b0);
                check_eq("arst_ovr", rx_if.overrun, 1'b0);
            end
        join
        idle_bits(1);
        reset = 1'b1;
        idle_bits(2);
        send_frame(8'h4B, 1'b1);
        idle_bits(2);
        check_eq("arst_next_data", rx_if.rx_data, 8'h4B);
        check_eq("arst_next_rises", valid_rises, 1);
        manual_ack();

        // Random bytes with random gaps; every good frame must arrive in order
        clear_counts();
        auto_ack = 1'b1;
        n = 10;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1);
            idle_bits(int'($urandom_range(0, 2)));
        end
        idle_bits(2);
        check_eq("rnd_count", got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check_eq($sformatf("rnd_byte%0d", i), got_q[i], exp_q[i]);
        end
        check_eq("rnd_ovr", ov_cnt, 0);
        check_eq("rnd_ferr", fe_cnt, 0);
        check_eq("never_both_pulses", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
